// File: rtl/modexp_engine_pkg.sv
// Shared RSA package: default widths, key type and FSM encodings used by the
// modular exponentiation engine and its Montgomery multiplier.
package modexp_engine_pkg;

    localparam int DEF_WIDTH     = 256;
    localparam int DEF_EXP_WIDTH = 256;

    typedef logic [DEF_EXP_WIDTH-1:0] key_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PACK  = 3'd1,
        MUL   = 3'd2,
        SQR   = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_BUSY = 2'd1,
        MM_DONE = 2'd2
    } mm_state_e;

endpackage

// File: rtl/modexp_engine_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: res = a*b*2^-WIDTH mod n.
// Operands must be below n and n must be odd; one result per request.
module mont_mult
    import modexp_engine_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int TW   = WIDTH + 2;
    localparam int CNTW = $clog2(WIDTH + 1);

    mm_state_e        st_q, st_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TW-1:0]    t_q, t_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [TW-1:0] n_ext_s;
    logic [TW-1:0] sum_s;
    logic [TW-1:0] sum_odd_s;
    logic [TW-1:0] shr_s;
    logic [TW-1:0] red_s;
    logic          last_s;
    logic          unused_red_s;

    // One Montgomery step; the accumulator stays below 2n, so sums stay below 4n.
    always_comb begin
        n_ext_s   = {2'b00, n_q};
        sum_s     = t_q + (a_q[0] ? {2'b00, b_q} : {TW{1'b0}});
        sum_odd_s = sum_s + (sum_s[0] ? n_ext_s : {TW{1'b0}});
        shr_s     = {1'b0, sum_odd_s[TW-1:1]};
        red_s     = (shr_s >= n_ext_s) ? (shr_s - n_ext_s) : shr_s;
        last_s    = (cnt_q == CNTW'(WIDTH - 1));
    end

    assign unused_red_s = ^red_s[TW-1:WIDTH];

    // Next-state logic for the multiplier handshake and iteration.
    always_comb begin
        st_d  = st_q;
        a_d   = a_q;
        b_d   = b_q;
        n_d   = n_q;
        t_d   = t_q;
        cnt_d = cnt_q;
        res_d = res_q;
        case (st_q)
            MM_IDLE: begin
                if (in_valid_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    n_d   = n_i;
                    t_d   = {TW{1'b0}};
                    cnt_d = {CNTW{1'b0}};
                    st_d  = MM_BUSY;
                end else begin
                    st_d = MM_IDLE;
                end
            end
            MM_BUSY: begin
                t_d   = shr_s;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNTW'(1);
                if (last_s) begin
                    res_d = red_s[WIDTH-1:0];
                    st_d  = MM_DONE;
                end else begin
                    st_d = MM_BUSY;
                end
            end
            MM_DONE: begin
                if (out_ready_i) begin
                    st_d = MM_IDLE;
                end else begin
                    st_d = MM_DONE;
                end
            end
            default: begin
                st_d = MM_IDLE;
            end
        endcase
    end

    // Multiplier state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= MM_IDLE;
            a_q   <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
            n_q   <= {WIDTH{1'b0}};
            t_q   <= {TW{1'b0}};
            cnt_q <= {CNTW{1'b0}};
            res_q <= {WIDTH{1'b0}};
        end else begin
            st_q  <= st_d;
            a_q   <= a_d;
            b_q   <= b_d;
            n_q   <= n_d;
            t_q   <= t_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign in_ready_o  = (st_q == MM_IDLE);
    assign out_valid_o = (st_q == MM_DONE);
    assign res_o       = res_q;

endmodule

// File: rtl/modexp_engine.sv
// Right-to-left binary modular exponentiation: msg^key mod N using one shared
// Montgomery multiplier. S holds msg^(2^idx) in Montgomery form, M the plain result.
module modexp_engine
    import modexp_engine_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_valid,
    output logic                               i_ready,
    input  logic [WIDTH-1:0]                   i_base,
    input  logic [WIDTH-1:0]                   i_msg,
    input  logic [EXP_WIDTH-1:0]               i_key,
    input  logic [$clog2(EXP_WIDTH+1)-1:0]     i_exp_len,
    input  logic [WIDTH-1:0]                   i_modulus,
    input  logic                               i_abort,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic [WIDTH-1:0]                   o_crypto,
    output logic [$clog2(2*EXP_WIDTH+2)-1:0]   o_mult_count
);

    localparam int LW = $clog2(EXP_WIDTH + 1);
    localparam int CW = $clog2(2 * EXP_WIDTH + 2);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [WIDTH-1:0]     msg_q, msg_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [EXP_WIDTH-1:0] key_q, key_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 inflight_q, inflight_d;

    logic                 mm_in_valid_s;
    logic                 mm_in_ready_s;
    logic [WIDTH-1:0]     mm_a_s;
    logic [WIDTH-1:0]     mm_b_s;
    logic                 mm_out_valid_s;
    logic                 mm_out_ready_s;
    logic [WIDTH-1:0]     mm_res_s;

    logic [LW-1:0]        len_clamp_s;
    logic [LW-1:0]        len_m1_s;
    logic [LW-1:0]        idx_nx_s;
    logic                 last_s;
    logic                 last_nx_s;
    logic [EXP_WIDTH-1:0] key_sh_s;

    // A set bit needs a multiply; a clear bit on the final index needs nothing more.
    function automatic state_e next_after(input logic key_bit, input logic is_last);
        state_e nxt;
        if (key_bit) begin
            nxt = MUL;
        end else if (is_last) begin
            nxt = DONE;
        end else begin
            nxt = SQR;
        end
        return nxt;
    endfunction

    mont_mult #(
        .WIDTH (WIDTH)
    ) u_mont (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (mm_in_valid_s),
        .in_ready_o  (mm_in_ready_s),
        .a_i         (mm_a_s),
        .b_i         (mm_b_s),
        .n_i         (mod_q),
        .out_valid_o (mm_out_valid_s),
        .out_ready_i (mm_out_ready_s),
        .res_o       (mm_res_s)
    );

    // Index bookkeeping shared by the decision logic.
    always_comb begin
        len_clamp_s = (i_exp_len > LW'(EXP_WIDTH)) ? LW'(EXP_WIDTH) : i_exp_len;
        len_m1_s    = len_q - LW'(1);
        idx_nx_s    = idx_q + LW'(1);
        last_s      = (idx_q == len_m1_s);
        last_nx_s   = (idx_nx_s == len_m1_s);
        key_sh_s    = key_q >> 1;
    end

    // Exponentiation FSM: operand selection, issue/return handshakes and abort.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        msg_d          = msg_q;
        mod_d          = mod_q;
        key_d          = key_q;
        len_d          = len_q;
        idx_d          = idx_q;
        s_d            = s_q;
        m_d            = m_q;
        cnt_d          = cnt_q;
        inflight_d     = inflight_q;
        mm_in_valid_s  = 1'b0;
        mm_out_ready_s = 1'b0;

        case (state_q)
            PACK: begin
                mm_a_s = base_q;
                mm_b_s = msg_q;
            end
            MUL: begin
                mm_a_s = s_q;
                mm_b_s = m_q;
            end
            SQR: begin
                mm_a_s = s_q;
                mm_b_s = s_q;
            end
            default: begin
                mm_a_s = {WIDTH{1'b0}};
                mm_b_s = {WIDTH{1'b0}};
            end
        endcase

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    base_d     = i_base;
                    msg_d      = i_msg;
                    mod_d      = i_modulus;
                    key_d      = i_key;
                    len_d      = len_clamp_s;
                    idx_d      = {LW{1'b0}};
                    cnt_d      = {CW{1'b0}};
                    s_d        = {WIDTH{1'b0}};
                    m_d        = WIDTH'(1);
                    inflight_d = 1'b0;
                    if (len_clamp_s == {LW{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = PACK;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PACK, MUL, SQR: begin
                if (inflight_q) begin
                    if (i_abort) begin
                        state_d = DRAIN;
                    end else if (mm_out_valid_s) begin
                        mm_out_ready_s = 1'b1;
                        inflight_d     = 1'b0;
                        cnt_d          = cnt_q + CW'(1);
                        case (state_q)
                            PACK: begin
                                s_d     = mm_res_s;
                                state_d = next_after(key_q[0], last_s);
                            end
                            MUL: begin
                                m_d = mm_res_s;
                                if (last_s) begin
                                    state_d = DONE;
                                end else begin
                                    state_d = SQR;
                                end
                            end
                            SQR: begin
                                s_d     = mm_res_s;
                                idx_d   = idx_nx_s;
                                key_d   = key_sh_s;
                                state_d = next_after(key_sh_s[0], last_nx_s);
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end else if (i_abort) begin
                    state_d = IDLE;
                end else begin
                    mm_in_valid_s = 1'b1;
                    inflight_d    = mm_in_ready_s;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                mm_out_ready_s = 1'b1;
                if (mm_out_valid_s) begin
                    inflight_d = 1'b0;
                    cnt_d      = cnt_q + CW'(1);
                    state_d    = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Engine registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= {WIDTH{1'b0}};
            msg_q      <= {WIDTH{1'b0}};
            mod_q      <= {WIDTH{1'b0}};
            key_q      <= {EXP_WIDTH{1'b0}};
            len_q      <= {LW{1'b0}};
            idx_q      <= {LW{1'b0}};
            s_q        <= {WIDTH{1'b0}};
            m_q        <= {WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            msg_q      <= msg_d;
            mod_q      <= mod_d;
            key_q      <= key_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            s_q        <= s_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign i_ready      = (state_q == IDLE);
    assign o_valid      = (state_q == DONE);
    assign o_crypto     = m_q;
    assign o_mult_count = cnt_q;

endmodule

// File: tb/tb_modexp_engine.sv
// Directed and randomised bench for modexp_engine at WIDTH=8 against a plain
// arithmetic exponentiation model.
module tb_modexp_engine;

    localparam int W  = 8;
    localparam int EW = 8;
    localparam int LW = $clog2(EW + 1);
    localparam int CW = $clog2(2 * EW + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  i_base;
    logic [W-1:0]  i_msg;
    logic [EW-1:0] i_key;
    logic [LW-1:0] i_exp_len;
    logic [W-1:0]  i_modulus;
    logic          i_abort;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_crypto;
    logic [CW-1:0] o_mult_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_base       (i_base),
        .i_msg        (i_msg),
        .i_key        (i_key),
        .i_exp_len    (i_exp_len),
        .i_modulus    (i_modulus),
        .i_abort      (i_abort),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_crypto     (o_crypto),
        .o_mult_count (o_mult_count)
    );

    // msg^(key restricted to its low len bits) mod n, by repeated multiplication
    function automatic int ref_pow(input int n, input int msg, input int key, input int len);
        int     l = (len > EW) ? EW : len;
        int     e = key & ((1 << l) - 1);
        longint r = 1;
        for (int k = 0; k < e; k++) r = (r * msg) % n;
        return int'(r % n);
    endfunction

    // one pack, one square per extra bit, one multiply per set bit
    function automatic int ref_cnt(input int key, input int len);
        int l  = (len > EW) ? EW : len;
        int pc = 0;
        for (int i = 0; i < l; i++) if (((key >> i) & 1) == 1) pc++;
        return (l == 0) ? 0 : (l + pc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (i_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (i_ready !== 1'b1) check("ready_timeout", i_ready, 1);
    endtask

    task automatic wait_count(input int c);
        int k = 0;
        while (o_mult_count !== CW'(c) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (o_mult_count !== CW'(c)) check("count_timeout", o_mult_count, c);
    endtask

    // returns one cycle after the accepting edge
    task automatic send(input int n, input int msg, input int key, input int len);
        wait_ready();
        i_base    = W'(65536 % n);
        i_msg     = W'(msg);
        i_key     = EW'(key);
        i_exp_len = LW'(len);
        i_modulus = W'(n);
        i_valid   = 1'b1;
        @(negedge clk);
        i_valid   = 1'b0;
    endtask

    task automatic await_result();
        int k = 0;
        while (o_valid !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("result_timeout", o_valid, 1);
    endtask

    task automatic run_one(input string tag, input int n, input int msg, input int key, input int len);
        send(n, msg, key, len);
        check({tag, "_cnt_clear"}, o_mult_count, 0);
        await_result();
        check({tag, "_crypto"}, o_crypto, ref_pow(n, msg, key, len));
        check({tag, "_count"}, o_mult_count, ref_cnt(key, len));
        check({tag, "_busy"}, i_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        int n, msg, key, len;
        logic saw_valid;

        rst       = 1'b0;
        i_valid   = 1'b0;
        i_base    = '0;
        i_msg     = '0;
        i_key     = '0;
        i_exp_len = '0;
        i_modulus = '0;
        i_abort   = 1'b0;
        o_ready   = 1'b1;
        #12;
        check("rst_ready", i_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_crypto", o_crypto, 0);
        check("rst_count", o_mult_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_one("k3l2", 187, 5, 3, 2);
        run_one("k5l3", 187, 5, 5, 3);

        // zero-length exponent completes one cycle after accept
        send(187, 5, 8'hFF, 0);
        check("len0_valid", o_valid, 1);
        check("len0_crypto", o_crypto, 1);
        check("len0_count", o_mult_count, 0);
        @(negedge clk);

        run_one("clamp", 187, 7, 8'hB5, 13);

        // result held under back-pressure; abort in DONE is ignored
        o_ready = 1'b0;
        send(187, 5, 3, 2);
        await_result();
        for (int c = 0; c < 10; c++) begin
            i_abort = (c == 4);
            check("hold_crypto", o_crypto, ref_pow(187, 5, 3, 2));
            check("hold_ready", i_ready, 0);
            check("hold_valid", o_valid, 1);
            @(negedge clk);
        end
        i_abort = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);

        // abort with nothing in flight: back to IDLE on the next edge
        send(187, 5, 3, 2);
        wait_count(1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_idle_now", i_ready, 1);

        // abort with a multiply in flight drains then idles without a result
        send(187, 5, 3, 2);
        wait_count(1);
        @(negedge clk);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_drain", i_ready, 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            saw_valid = saw_valid | o_valid;
            @(negedge clk);
        end
        check("abort_no_valid", saw_valid, 0);
        check("abort_idle", i_ready, 1);
        run_one("post_abort", 187, 5, 3, 2);

        // reset in the middle of a square
        send(187, 5, 3, 2);
        wait_count(2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_valid", o_valid, 0);
        check("mrst_crypto", o_crypto, 0);
        check("mrst_count", o_mult_count, 0);
        check("mrst_ready", i_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            saw_valid = saw_valid | o_valid;
            @(negedge clk);
        end
        check("mrst_no_stale", saw_valid, 0);
        run_one("post_rst", 187, 5, 3, 2);

        for (int t = 0; t < 25; t++) begin
            n   = int'($urandom_range(1, 127)) * 2 + 1;
            msg = int'($urandom_range(0, n - 1));
            key = int'($urandom_range(0, 255));
            len = int'($urandom_range(0, 15));
            run_one("rand", n, msg, key, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/modexp_engine.md
MODEXP_ENGINE -- requirements
Module: modexp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 256: modulus, operand and result width in bits.
REQ-002 SHALL have parameter EXP_WIDTH, default 256: exponent register width in bits.
REQ-003 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, 1: request valid.
REQ-006 SHALL have port i_ready, output, 1: request accepted when i_valid && i_ready.
REQ-007 SHALL have port i_base, input, WIDTH: R^2 mod N, where R = 2^WIDTH.
REQ-008 SHALL have port i_msg, input, WIDTH: message, value < N.
REQ-009 SHALL have port i_key, input, EXP_WIDTH: exponent, scanned LSB first.
REQ-010 SHALL have port i_exp_len, input, $clog2(EXP_WIDTH+1): number of exponent bits to process.
REQ-011 SHALL have port i_modulus, input, WIDTH: N, odd.
REQ-012 SHALL have port i_abort, input, 1: cancel the current operation.
REQ-013 SHALL have port o_valid, output, 1: result valid.
REQ-014 SHALL have port o_ready, input, 1: result consumed when o_valid && o_ready.
REQ-015 SHALL have port o_crypto, output, WIDTH: msg^key mod N.
REQ-016 SHALL have port o_mult_count, output, $clog2(2*EXP_WIDTH+2): Montgomery operations used for the current/last result.

Function
REQ-017 SHALL implement states IDLE, PACK, MUL, SQR, DONE, DRAIN; i_ready = (state==IDLE); o_valid = (state==DONE).
REQ-018 On accept SHALL register all inputs; i_exp_len > EXP_WIDTH SHALL be clamped to EXP_WIDTH; bit index idx SHALL reset to 0; o_mult_count SHALL clear to 0.
REQ-019 On accept with clamped len==0 SHALL go to DONE with M=1, issuing no Montgomery operation.
REQ-020 Otherwise SHALL go to PACK: S = Mont(base, msg) = msg·R mod N; M = 1.
REQ-021 After PACK, and after each SQR, SHALL go to MUL if key[idx]==1, else directly to SQR (zero bits SHALL issue no multiply).
REQ-022 MUL SHALL compute M = Mont(S, M); SQR SHALL compute S = Mont(S, S) then increment idx.
REQ-023 After MUL, or after deciding to skip MUL, SHALL skip SQR and go to DONE when idx == len-1.
REQ-024 Each Montgomery operation SHALL be exactly one valid/ready transfer into the multiplier followed by exactly one result transfer; the next operation SHALL NOT issue before the previous result returns.
REQ-025 o_mult_count SHALL increment on each multiplier result transfer, PACK included.
REQ-026 o_crypto SHALL equal M and SHALL be held stable while o_valid && !o_ready.
REQ-027 DONE -> IDLE SHALL occur on o_ready; a new request SHALL NOT be accepted in the same cycle.
REQ-028 i_abort in PACK/MUL/SQR with no operation in flight SHALL go to IDLE next cycle.
REQ-029 i_abort with an operation in flight SHALL go to DRAIN, discard the result on return, then go to IDLE.
REQ-030 i_abort in IDLE or DONE SHALL be ignored.
REQ-031 Latency SHALL be the sum of multiplier latencies plus 1 cycle per state transition; throughput SHALL be one request at a time.

Reset
REQ-032 rst low SHALL asynchronously set state=IDLE, o_valid=0, i_ready=1 after release, o_crypto=0, o_mult_count=0, idx=0, and all operand registers to 0.
REQ-033 Reset mid-operation SHALL also reset the multiplier instance; no result from before reset SHALL appear.

Structure
REQ-034 WIDTH-dependent KeyType, state enum and default parameters SHALL live in the shared RSA package.
REQ-035 SHALL instantiate one sub-module, mont_mult (parametrised WIDTH, valid/ready in and out, computes a·b·R^-1 mod N).

Verification (WIDTH=8, N=187, R^2 mod N=86)
REQ-036 msg=5, key=3, len=2 -> o_crypto=125, o_mult_count=4.
REQ-037 msg=5, key=5, len=3 -> o_crypto=133, o_mult_count=5 (zero bit issues no multiply).
REQ-038 msg=5, key=0xFF, len=0 -> o_crypto=1, o_mult_count=0, o_valid 1 cycle after accept.
REQ-039 msg=5, key=3, len=2, o_ready held low 10 cycles -> o_crypto stable at 125, i_ready=0 throughout.
REQ-040 i_abort pulsed during the first MUL (operation in flight) -> DRAIN, then IDLE; no o_valid; next request msg=5, key=3, len=2 -> 125.
REQ-041 rst asserted mid-SQR -> all outputs at reset values immediately; a following request completes correctly.
